// File: rtl/instr_mem_responder_if.sv
// Fetch and program-load signals between the CPU (or bench) and the
// instruction-memory responder.
interface instr_mem_responder_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  READ;
  logic [31:0]           ADDRESS;
  logic [31:0]           INSTRUCTION;
  logic                  BUSYWAIT;
  logic                  LOAD_EN;
  logic [ADDR_WIDTH-1:0] LOAD_ADDR;
  logic [7:0]            LOAD_DATA;

  modport master (
    output READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
    input  INSTRUCTION, BUSYWAIT
  );

  modport slave (
    input  READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
    output INSTRUCTION, BUSYWAIT
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: byte-array program store with a fixed
// multi-cycle read latency and a one-word last-fetch buffer so that repeated
// fetches of the same word complete without stalling the CPU.
module instr_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input logic                 CLK,
  input logic                 RESET,
  instr_mem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE, FETCH} state_t;

  logic [7:0]       mem [DEPTH];
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] fetch_idx;
  logic             buf_valid;
  logic [IDX_W-1:0] buf_idx;
  logic [31:0]      buf_data;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] load_idx;
  logic             hit;
  logic             load_hits_buf;
  logic             load_hits_fetch;
  logic [31:0]      fetch_word;
  logic             unused_addr;

  // Byte offset and bits above the memory size alias away.
  assign idx             = bus.ADDRESS[ADDR_WIDTH-1:2];
  assign unused_addr     = ^{bus.ADDRESS[31:ADDR_WIDTH], bus.ADDRESS[1:0]};
  assign load_idx        = bus.LOAD_ADDR[ADDR_WIDTH-1:2];
  assign hit             = buf_valid && (buf_idx == idx);
  assign load_hits_buf   = bus.LOAD_EN && (load_idx == buf_idx);
  assign load_hits_fetch = bus.LOAD_EN && (load_idx == fetch_idx);
  assign fetch_word      = {mem[{fetch_idx, 2'd3}], mem[{fetch_idx, 2'd2}],
                            mem[{fetch_idx, 2'd1}], mem[{fetch_idx, 2'd0}]};

  assign bus.INSTRUCTION = buf_data;
  // Reset forces the stall low even though READ may still be asserted.
  assign bus.BUSYWAIT    = !RESET && ((state == FETCH) || (bus.READ && !hit));

  // Program store; deliberately not cleared by reset.
  always_ff @(posedge CLK) begin
    if (bus.LOAD_EN) mem[bus.LOAD_ADDR] <= bus.LOAD_DATA;
  end

  // Fetch sequencer and last-fetch buffer; a load into the buffered word
  // invalidates it, and that invalidate wins over a coincident fill.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      fetch_idx <= '0;
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_hits_buf) buf_valid <= 1'b0;
          if (bus.READ && !hit) begin
            fetch_idx <= idx;
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (cnt == '0) begin
            buf_data  <= fetch_word;
            buf_idx   <= fetch_idx;
            buf_valid <= !load_hits_fetch;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (load_hits_buf) buf_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
